// File: rtl/fsm_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fsm_step_sequencer
// Description : Drives a two-input handshake FSM (IDLE/S1/S2/ER) through
//               complete IDLE->S1->S2->IDLE rounds. It generates the target's
//               i1/i2 stimulus, checks the o1/o2/err response, and recovers
//               the target from ER with a bounded number of retries per round.
// Ports       : clk_i        - clock, rising edge
//               rst_ni       - asynchronous active-low reset
//               start_i      - begin a run (sampled only in IDLE)
//               n_rounds_i   - rounds to execute (sampled with start_i)
//               o1_i/o2_i/err_i - target FSM outputs
//               i1_o/i2_o    - target FSM inputs (registered)
//               busy_o       - high in every state except IDLE
//               done_o       - one-cycle pulse, run completed
//               fail_o       - one-cycle pulse, run aborted
//               round_cnt_o  - rounds completed in the current run
//               err_cnt_o    - errors in the current run (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_step_sequencer #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_rounds_i,
  input  logic             o1_i,
  input  logic             o2_i,
  input  logic             err_i,
  output logic             i1_o,
  output logic             i2_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] round_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GO1   = 4'd1;
  localparam logic [3:0] S_W1    = 4'd2;
  localparam logic [3:0] S_GO2   = 4'd3;
  localparam logic [3:0] S_W2    = 4'd4;
  localparam logic [3:0] S_GO3   = 4'd5;
  localparam logic [3:0] S_W3    = 4'd6;
  localparam logic [3:0] S_RECOV = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_FAIL  = 4'd9;

  logic [3:0]         state_q,   state_d;
  logic [CNT_W-1:0]   round_q,   round_d;
  logic [CNT_W-1:0]   errc_q,    errc_d;
  logic [CNT_W-1:0]   nrounds_q, nrounds_d;
  logic [RETRY_W-1:0] retry_q,   retry_d;
  logic [WAIT_W-1:0]  wait_q,    wait_d;
  logic               i1_q, i1_d, i2_q, i2_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;

  logic [2:0]         obs;
  logic               is_wait;
  logic               exit_ok;
  logic               timeout;
  logic [CNT_W-1:0]   errc_inc;

  assign obs      = {o1_i, o2_i, err_i};
  assign timeout  = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign errc_inc = (&errc_q) ? errc_q : errc_q + CNT_W'(1);

  // Exit condition of the current wait state, expressed as the expected code.
  always_comb begin
    exit_ok = 1'b0;
    is_wait = 1'b1;
    case (state_q)
      S_W1:    exit_ok = (obs == 3'b100);
      S_W2:    exit_ok = (obs == 3'b010);
      S_W3:    exit_ok = (obs == 3'b000);
      S_RECOV: exit_ok = (obs == 3'b000);
      default: is_wait = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    errc_d    = errc_q;
    nrounds_d = nrounds_q;
    retry_d   = retry_q;
    wait_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          round_d   = '0;
          errc_d    = '0;
          retry_d   = '0;
          nrounds_d = n_rounds_i;
          state_d   = (n_rounds_i == '0) ? S_DONE : S_GO1;
        end
      end
      S_GO1: state_d = S_W1;
      S_GO2: state_d = S_W2;
      S_GO3: state_d = S_W3;
      S_W1, S_W2, S_W3: begin
        // err takes priority over a coincident exit code.
        if (err_i || (!exit_ok && timeout)) begin
          errc_d = errc_inc;
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_RECOV;
          end
        end else if (exit_ok) begin
          case (state_q)
            S_W1:    state_d = S_GO2;
            S_W2:    state_d = S_GO3;
            default: begin
              round_d = round_q + CNT_W'(1);
              retry_d = '0;
              state_d = (round_d == nrounds_q) ? S_DONE : S_GO1;
            end
          endcase
        end
      end
      S_RECOV: begin
        // Round restarts from GO1 with round_cnt untouched.
        if (exit_ok) begin
          state_d = S_GO1;
        end else if (timeout) begin
          errc_d  = errc_inc;
          state_d = S_FAIL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Wait counter restarts on every entry into a wait state.
    if (is_wait && (state_d == state_q)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they belong to.
  always_comb begin
    i1_d = 1'b0;
    i2_d = 1'b0;
    case (state_d)
      S_GO1, S_GO2: begin
        i1_d = 1'b1;
        i2_d = 1'b1;
      end
      S_W1, S_GO3: i1_d = 1'b1;
      S_W2:        i2_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      errc_q    <= '0;
      nrounds_q <= '0;
      retry_q   <= '0;
      wait_q    <= '0;
      i1_q      <= 1'b0;
      i2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      errc_q    <= errc_d;
      nrounds_q <= nrounds_d;
      retry_q   <= retry_d;
      wait_q    <= wait_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign i1_o        = i1_q;
  assign i2_o        = i2_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign round_cnt_o = round_q;
  assign err_cnt_o   = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_step_sequencer
// Description : Directed bench for fsm_step_sequencer with a behavioural
//               model of the handshake target FSM (fault injection: one-shot
//               ER on S1->S2, and o1 stuck at 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] n_rounds = 8'd0;
  logic       o1, o2, err;
  logic       i1, i2, busy, done, fail;
  logic [7:0] round_cnt, err_cnt;

  int checks = 0;
  int failures = 0;

  // Target model state and fault controls
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_S1   = 2'd1;
  localparam logic [1:0] T_S2   = 2'd2;
  localparam logic [1:0] T_ER   = 2'd3;
  logic [1:0] tgt = T_IDLE;
  logic       inj_req = 1'b0;
  logic       inj_used = 1'b0;
  logic       stuck_o1 = 1'b0;
  logic [2:0] tcode;

  always #5 clk = ~clk;

  fsm_step_sequencer #(.CNT_W(8), .TIMEOUT(15), .MAX_RETRY(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_rounds_i(n_rounds),
    .o1_i(o1), .o2_i(o2), .err_i(err),
    .i1_o(i1), .i2_o(i2), .busy_o(busy), .done_o(done), .fail_o(fail),
    .round_cnt_o(round_cnt), .err_cnt_o(err_cnt)
  );

  always_comb begin
    case (tgt)
      T_S1:    tcode = 3'b100;
      T_S2:    tcode = 3'b010;
      T_ER:    tcode = 3'b111;
      default: tcode = 3'b000;
    endcase
  end
  assign o1  = tcode[2] & ~stuck_o1;
  assign o2  = tcode[1];
  assign err = tcode[0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt      <= T_IDLE;
      inj_used <= 1'b0;
    end else begin
      if (!inj_req) inj_used <= 1'b0;
      case (tgt)
        T_IDLE: if ({i1, i2} == 2'b11) tgt <= T_S1;
                else if ({i1, i2} != 2'b00) tgt <= T_ER;
        T_S1: begin
          if ({i1, i2} == 2'b11) begin
            if (inj_req && !inj_used) begin
              tgt      <= T_ER;
              inj_used <= 1'b1;
            end else begin
              tgt <= T_S2;
            end
          end else if ({i1, i2} == 2'b00) tgt <= T_IDLE;
          else if ({i1, i2} != 2'b10) tgt <= T_ER;
        end
        T_S2: if ({i1, i2} == 2'b10 || {i1, i2} == 2'b00) tgt <= T_IDLE;
              else if ({i1, i2} != 2'b01) tgt <= T_ER;
        default: if ({i1, i2} == 2'b00) tgt <= T_IDLE;
      endcase
    end
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns just after edge s.
  task automatic do_start(input logic [7:0] n);
    start    = 1'b1;
    n_rounds = n;
    tick();
    start = 1'b0;
  endtask

  logic [1:0] pat [6];
  logic [1:0] exp3 [18];
  logic [1:0] ei;
  int unsigned ee;

  initial begin
    pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b11;
    pat[3] = 2'b01; pat[4] = 2'b10; pat[5] = 2'b00;

    // ---- reset held, then released with start=0
    repeat (3) tick();
    chk("reset_hold", {i1, i2, busy, done, fail, round_cnt, err_cnt}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_after_reset", {i1, i2, busy, done, fail, round_cnt, err_cnt}, 0);
    end

    // ---- fault-free, 3 rounds
    do_start(8'd3);
    for (int k = 0; k < 18; k++) begin
      chk("run3_seq", {i1, i2, busy, done, fail}, {pat[k % 6], 3'b100});
      tick();
    end
    chk("run3_done", {busy, done, fail, round_cnt, err_cnt}, {3'b110, 8'd3, 8'd0});
    tick();
    chk("run3_idle", {busy, done, fail, round_cnt}, {3'b000, 8'd3});

    // ---- ER injected in first W2, 2 rounds
    for (int k = 0; k < 18; k++) exp3[k] = pat[k % 6];
    exp3[3] = 2'b01; exp3[4] = 2'b00; exp3[5] = 2'b00;
    for (int k = 6; k < 18; k++) exp3[k] = pat[(k - 6) % 6];
    inj_req = 1'b1;
    tick();
    do_start(8'd2);
    for (int k = 0; k < 18; k++) begin
      chk("recov_seq", {i1, i2, done, fail}, {exp3[k], 2'b00});
      if (k == 4) chk("recov_errcnt", {round_cnt, err_cnt}, {8'd0, 8'd1});
      tick();
    end
    chk("recov_done", {done, fail, round_cnt, err_cnt}, {2'b10, 8'd2, 8'd1});
    tick();
    chk("recov_idle", {busy, fail}, 0);
    inj_req = 1'b0;

    // ---- o1 stuck at 0: four 15-cycle timeouts in W1, then FAIL
    stuck_o1 = 1'b1;
    tick();
    do_start(8'd1);
    for (int k = 1; k <= 68; k++) begin
      tick();
      if (k == 16 || k == 33 || k == 50 || k >= 67) ei = 2'b00;
      else if (k == 17 || k == 34 || k == 51)    ei = 2'b11;
      else                                          ei = 2'b10;
      ee = (k >= 67) ? 4 : (k >= 50) ? 3 : (k >= 33) ? 2 : (k >= 16) ? 1 : 0;
      chk("stuck_seq", {i1, i2, fail, err_cnt},
          {ei, (k == 67) ? 1'b1 : 1'b0, 8'(ee)});
    end
    chk("stuck_end", {busy, done, fail, round_cnt, err_cnt}, {3'b000, 8'd0, 8'd4});
    stuck_o1 = 1'b0;
    tick();

    // ---- n_rounds == 0
    do_start(8'd0);
    chk("zero_done", {i1, i2, busy, done, fail, round_cnt, err_cnt}, {5'b00110, 8'd0, 8'd0});
    tick();
    chk("zero_idle", {i1, i2, busy, done, round_cnt}, 0);

    // ---- asynchronous reset during W2 of round 2
    do_start(8'd3);
    repeat (9) tick();
    chk("pre_rst_w2", {i1, i2, busy, round_cnt}, {2'b01, 1'b1, 8'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {i1, i2, busy, done, fail, round_cnt, err_cnt}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- follow-up run with start pulses while busy
    do_start(8'd1);
    for (int k = 0; k < 6; k++) begin
      chk("follow_seq", {i1, i2, busy, done}, {pat[k], 2'b10});
      start    = (k == 2);
      n_rounds = 8'd5;
      tick();
    end
    chk("follow_done", {done, round_cnt}, {1'b1, 8'd1});
    start = 1'b1;   // sampled while in DONE: must be ignored
    tick();
    start = 1'b0;
    chk("busy_start_ign", {busy, done, round_cnt}, {2'b00, 8'd1});
    tick();
    chk("no_extra_round", {i1, i2, busy, round_cnt}, {3'b000, 8'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
